// File: rtl/mac_row_seq.sv
// mac_row_seq: kernel-load / execute / drain sequencer feeding the SRAM->L0->mac_row datapath.
module mac_row_seq #(
  parameter int col       = 8,
  parameter int addr_bw   = 11,
  parameter int len_bw    = 8,
  parameter int KGAP_CYC  = 16,
  parameter int DRAIN_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [len_bw-1:0]  x_len,
  input  logic               ready,
  output logic               mem_rd,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
);
  localparam int C1 = $clog2(col + 1);
  localparam int C2 = $clog2(KGAP_CYC + 1);
  localparam int C3 = $clog2(DRAIN_CYC + 1);
  localparam int M1 = C1 > C2 ? C1 : C2;
  localparam int M2 = M1 > C3 ? M1 : C3;
  localparam int CW = M2 > len_bw ? M2 : len_bw;
  typedef enum logic [2:0] {IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE} state_e;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [addr_bw-1:0] ptr_q, ptr_d, xb_q, xb_d, addr_q;
  logic [len_bw-1:0]  xl_q, xl_d;
  logic [1:0]         iw_q, iw_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      xb_q    <= '0;
      xl_q    <= '0;
      addr_q  <= '0;
      iw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      xb_q    <= xb_d;
      xl_q    <= xl_d;
      addr_q  <= mem_addr;
      iw_q    <= iw_d;
    end
  end
  assign cnt_inc = cnt_q + CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    xb_d    = xb_q;
    xl_d    = xl_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = KLOAD;
        cnt_d   = '0;
        ptr_d   = w_base;
        xb_d    = x_base;
        xl_d    = x_len;
      end
      KLOAD: if (ready) begin
        ptr_d = ptr_q + addr_bw'(1);
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(col)) begin
          state_d = KGAP;
          cnt_d   = '0;
        end
      end
      KGAP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(KGAP_CYC)) begin
          state_d = xl_q != '0 ? EXEC : DRAIN;
          cnt_d   = '0;
          ptr_d   = xb_q;
        end
      end
      EXEC: if (ready) begin
        ptr_d = ptr_q + addr_bw'(1);
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(xl_q)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(DRAIN_CYC)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // inst_w is delayed one cycle so it lines up with the SRAM read data
  always_comb begin
    mem_rd   = (state_q == KLOAD || state_q == EXEC) && ready;
    mem_addr = mem_rd ? ptr_q : addr_q;
    iw_d     = mem_rd ? (state_q == EXEC ? 2'b10 : 2'b01) : 2'b00;
    inst_w   = iw_q;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
  end
endmodule

// File: tb/tb_mac_row_seq.sv
// tb_mac_row_seq: table, hand-written and randomized checks of mac_row_seq against a job-level model.
module tb_mac_row_seq;
  localparam int MAXC = 1024;
  logic clk = 0, reset, start, ready, mem_rd, busy, done;
  logic [10:0] w_base, x_base, mem_addr;
  logic [7:0] x_len;
  logic [1:0] inst_w;
  always #5 clk = ~clk;
  mac_row_seq dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .x_len(x_len), .ready(ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .inst_w(inst_w), .busy(busy), .done(done)
  );
  int checks = 0, failures = 0;
  bit rdy[MAXC], st[MAXC], rs[MAXC];
  int o_rd[MAXC], o_ad[MAXC], o_iw[MAXC], o_bz[MAXC], o_dn[MAXC];
  int e_rd[MAXC], e_ad[MAXC], e_iw[MAXC], e_bz[MAXC], e_dn[MAXC];
  logic [10:0] la = 0;
  typedef struct {int cyc; int rd; int ad; int iw; int bz; int dn;} vec_t;
  vec_t tbl[14];
  always @(negedge clk)
    if (inst_w === 2'b11) begin
      failures++;
      $display("FAIL inst_w11 got=11 want=not11");
    end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic clr(bit rnd);
    for (int c = 0; c < MAXC; c++) begin
      rdy[c] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      st[c] = 0;
      rs[c] = 0;
    end
  endtask
  task automatic run(int n);
    for (int c = 0; c < n; c++) begin
      start = st[c];
      ready = rdy[c];
      reset = rs[c];
      @(negedge clk);
      o_rd[c] = mem_rd; o_ad[c] = mem_addr; o_iw[c] = inst_w; o_bz[c] = busy; o_dn[c] = done;
      @(posedge clk);
      #1;
    end
    start = 0;
    reset = 0;
  endtask
  // job model: the k-th read of a phase lands on the k-th ready cycle of that phase
  function automatic int build(logic [10:0] wb, logic [10:0] xb, int xl);
    int t = 1, k = 0;
    logic [10:0] a;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_ad[c] = 0; e_iw[c] = 0; e_bz[c] = 0; e_dn[c] = 0;
    end
    while (k < 8 && t < MAXC - 40) begin
      if (rdy[t]) begin e_rd[t] = 1; e_ad[t] = int'(11'(wb + 11'(k))); e_iw[t+1] = 1; k++; end
      t++;
    end
    t += 16;
    k = 0;
    while (k < xl && t < MAXC - 40) begin
      if (rdy[t]) begin e_rd[t] = 1; e_ad[t] = int'(11'(xb + 11'(k))); e_iw[t+1] = 2; k++; end
      t++;
    end
    t += 16;
    for (int c = 1; c <= t; c++) e_bz[c] = 1;
    e_dn[t] = 1;
    a = la;
    for (int c = 0; c <= t + 2; c++) begin
      if (e_rd[c] != 0) a = 11'(e_ad[c]);
      e_ad[c] = int'(a);
    end
    la = a;
    return t + 3;
  endfunction
  task automatic cmp_model(string nm, int n);
    for (int c = 0; c < n; c++)
      chk($sformatf("%s_c%0d", nm, c),
          (o_rd[c] << 16) | (o_ad[c] << 4) | (o_iw[c] << 2) | (o_bz[c] << 1) | o_dn[c],
          (e_rd[c] << 16) | (e_ad[c] << 4) | (e_iw[c] << 2) | (e_bz[c] << 1) | e_dn[c]);
  endtask
  task automatic job(string nm, logic [10:0] wb, logic [10:0] xb, int xl, bit rnd_start);
    int n;
    w_base = wb; x_base = xb; x_len = 8'(xl);
    n = build(wb, xb, xl);
    st[0] = 1;
    if (rnd_start) for (int c = 1; c < n - 3; c++) st[c] = $urandom_range(0, 1) != 0;
    run(n);
    cmp_model(nm, n);
  endtask
  initial begin
    int n, cnt;
    int kad[8];
    tbl = '{'{1, 1, 'h010, 0, 1, 0}, '{2, 1, 'h011, 1, 1, 0}, '{8, 1, 'h017, 1, 1, 0},
            '{9, 0, 'h017, 1, 1, 0}, '{10, 0, 'h017, 0, 1, 0}, '{24, 0, 'h017, 0, 1, 0},
            '{25, 1, 'h100, 0, 1, 0}, '{26, 1, 'h101, 2, 1, 0}, '{28, 1, 'h103, 2, 1, 0},
            '{29, 0, 'h103, 2, 1, 0}, '{30, 0, 'h103, 0, 1, 0}, '{44, 0, 'h103, 0, 1, 0},
            '{45, 0, 'h103, 0, 1, 1}, '{46, 0, 'h103, 0, 0, 0}};
    reset = 1; start = 0; ready = 1; w_base = 0; x_base = 0; x_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", mem_rd, 0); chk("rst_addr", mem_addr, 0); chk("rst_iw", inst_w, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(posedge clk); #1;
    clr(0);
    job("basic", 11'h010, 11'h100, 4, 0);
    for (int i = 0; i < 14; i++) begin
      int c;
      c = tbl[i].cyc;
      chk($sformatf("tbl_c%0d", c), (o_rd[c] << 16) | (o_ad[c] << 4) | (o_iw[c] << 2) | (o_bz[c] << 1) | o_dn[c],
          (tbl[i].rd << 16) | (tbl[i].ad << 4) | (tbl[i].iw << 2) | (tbl[i].bz << 1) | tbl[i].dn);
    end
    clr(0); rdy[4] = 0; rdy[5] = 0;
    job("stall", 11'h010, 11'h100, 4, 0);
    chk("stall_rd4", o_rd[4], 0); chk("stall_ad6", o_ad[6], 'h013);
    chk("stall_iw5", o_iw[5], 0); chk("stall_iw6", o_iw[6], 0);
    chk("stall_dn45", o_dn[45], 0); chk("stall_dn47", o_dn[47], 1);
    cnt = 0; for (int c = 0; c < 60; c++) cnt += (o_iw[c] == 1) ? 1 : 0;
    chk("stall_kwords", cnt, 8);
    clr(0);
    job("zero", 11'h020, 11'h300, 0, 0);
    chk("zero_dn41", o_dn[41], 1);
    cnt = 0; for (int c = 0; c < 50; c++) cnt += (o_iw[c] == 2) ? 1 : 0;
    chk("zero_no_exec", cnt, 0);
    clr(0); st[26] = 1; st[27] = 1;
    job("wrap", 11'h7FC, 11'h200, 5, 0);
    kad = '{'h7FC, 'h7FD, 'h7FE, 'h7FF, 'h000, 'h001, 'h002, 'h003};
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_ad%0d", i), o_ad[i+1], kad[i]);
    cnt = 0; for (int c = 0; c < 60; c++) cnt += o_dn[c];
    chk("wrap_one_done", cnt, 1);
    for (int j = 0; j < 6; j++) begin
      clr(1);
      job($sformatf("rnd%0d", j), 11'($urandom), 11'($urandom), $urandom_range(0, 40), 1);
    end
    clr(0);
    job("maxlen", 11'h400, 11'h7F0, 255, 0);
    clr(0); st[0] = 1; rs[26] = 1;
    w_base = 11'h010; x_base = 11'h100; x_len = 4;
    run(80);
    chk("rst_mid_rd", o_rd[27], 0); chk("rst_mid_iw", o_iw[27], 0);
    chk("rst_mid_busy", o_bz[27], 0); chk("rst_mid_addr", o_ad[27], 0);
    cnt = 0; for (int c = 0; c < 80; c++) cnt += o_dn[c];
    chk("rst_mid_nodone", cnt, 0);
    la = 0;
    clr(0);
    job("after_rst", 11'h010, 11'h100, 4, 0);
    clr(0);
    for (int c = 0; c < 91; c++) st[c] = 1;
    w_base = 11'h050; x_base = 11'h150; x_len = 4;
    run(140);
    chk("b2b_dn45", o_dn[45], 1); chk("b2b_idle46", o_bz[46], 0);
    chk("b2b_rd47", o_rd[47], 1); chk("b2b_ad47", o_ad[47], 'h050);
    chk("b2b_dn91", o_dn[91], 1);
    cnt = 0; for (int c = 0; c < 140; c++) cnt += o_dn[c];
    chk("b2b_two_done", cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
